// File: rtl/instruction_sequencer_if.sv
// Host/control-unit bus of the instruction sequencer.
// SEQ_SINGLE_STEP_EN adds the step_mode/step pair.
interface instruction_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int GAP_W  = 8
);
    logic                    prog_we;
    logic [ADDR_W-1:0]       prog_addr;
    logic [24+GAP_W-1:0]     prog_data;
    logic                    start;
    logic [ADDR_W:0]         prog_len;
    logic                    stall;
    logic                    abort;
    logic [23:0]             instruction;
    logic                    instr_valid;
    logic [ADDR_W-1:0]       pc;
    logic                    busy;
    logic                    done;
    logic                    prog_err;
`ifdef SEQ_SINGLE_STEP_EN
    logic                    step_mode;
    logic                    step;

    modport master (
        output prog_we, prog_addr, prog_data, start, prog_len, stall, abort, step_mode, step,
        input  instruction, instr_valid, pc, busy, done, prog_err
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, start, prog_len, stall, abort, step_mode, step,
        output instruction, instr_valid, pc, busy, done, prog_err
    );
`else
    modport master (
        output prog_we, prog_addr, prog_data, start, prog_len, stall, abort,
        input  instruction, instr_valid, pc, busy, done, prog_err
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, start, prog_len, stall, abort,
        output instruction, instr_valid, pc, busy, done, prog_err
    );
`endif
endinterface

// File: rtl/instruction_sequencer.sv
// Program sequencer issuing 24-bit control words from a preloaded RAM with bubbles.
// Optional single-step issue gated by `define SEQ_SINGLE_STEP_EN.
module instruction_sequencer #(
    parameter int ADDR_W = 6,
    parameter int GAP_W  = 8
) (
    input logic clk,
    input logic rst,
    instruction_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t state, state_n;
    logic [24+GAP_W-1:0] mem [DEPTH];
    logic [24+GAP_W-1:0] entry;
    logic [GAP_W-1:0]    bubble;
    logic [ADDR_W-1:0]   pc_q, pc_n;
    logic [ADDR_W:0]     len_q, len_n, cnt_q, cnt_n, cnt_inc;
    logic [GAP_W-1:0]    gap_q, gap_n;
    logic [23:0]         instr_q, instr_n;
    logic                valid_q, valid_n, busy_q, busy_n, done_q, done_n, err_q, err_n;
    logic                mem_we, issue_ok, running;

`ifdef SEQ_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge clk) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= bus.step;
    end

    assign issue_ok = !bus.stall && (!bus.step_mode || (bus.step && !step_q));
`else
    assign issue_ok = !bus.stall;
`endif

    assign entry   = mem[pc_q];
    assign bubble  = entry[24 +: GAP_W];
    assign cnt_inc = cnt_q + 1'b1;
    assign running = (state == RUN) || (state == GAP);

    always_ff @(posedge clk) begin
        if (mem_we) mem[bus.prog_addr] <= bus.prog_data;
    end

    // Completion is judged by the issued count, so a full-depth program works even though pc wraps.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        gap_n   = gap_q;
        instr_n = '0;
        valid_n = 1'b0;
        done_n  = 1'b0;
        err_n   = err_q;
        mem_we  = 1'b0;

        if (running && bus.prog_we) err_n = 1'b1;

        unique case (state)
            IDLE: begin
                mem_we = bus.prog_we;
                if (bus.start) begin
                    if (bus.prog_len != '0 && bus.prog_len <= DEPTH_LEN) begin
                        state_n = RUN;
                        len_n   = bus.prog_len;
                        pc_n    = '0;
                        cnt_n   = '0;
                        err_n   = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_ok) begin
                    instr_n = entry[23:0];
                    valid_n = 1'b1;
                    pc_n    = pc_q + 1'b1;
                    cnt_n   = cnt_inc;
                    gap_n   = bubble;
                    if (bubble != '0)          state_n = GAP;
                    else if (cnt_inc == len_q) state_n = DONE;
                end
            end
            GAP: begin
                gap_n = gap_q - 1'b1;
                if (gap_q <= GAP_W'(1)) state_n = (cnt_q == len_q) ? DONE : RUN;
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            pc_n    = pc_q;
            instr_n = '0;
            valid_n = 1'b0;
            done_n  = 1'b0;
        end

        busy_n = (state_n == RUN) || (state_n == GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            len_q   <= len_n;
            cnt_q   <= cnt_n;
            gap_q   <= gap_n;
            instr_q <= instr_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.prog_err    = err_q;
endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Program sequencer that feeds the 24-bit control word consumed by the TPU control unit. A host preloads a small program RAM. On a start pulse the block issues one instruction per cycle to the control unit, honouring datapath back-pressure and a per-instruction bubble count. Between issued words it drives an all-zero word, which the control unit decodes as a no-op.

Parameters:
ADDR_W, 6, program RAM address width; DEPTH = 2**ADDR_W entries (default 64)
GAP_W, 8, width of per-instruction bubble field

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
prog_we  input  1  program RAM write strobe
prog_addr  input  ADDR_W  program RAM write address
prog_data  input  24+GAP_W  entry: [23:0] control word, [24+GAP_W-1:24] bubble count
start  input  1  begin program execution (single-cycle pulse)
prog_len  input  ADDR_W+1  number of entries to execute; sampled with start
stall  input  1  datapath back-pressure; hold issue while high
abort  input  1  terminate execution
instruction  output  24  control word to control unit; 0 when not issuing
instr_valid  output  1  high in cycles where instruction is an issued program word
pc  output  ADDR_W  index of next entry to issue
busy  output  1  high in RUN and GAP states
done  output  1  one-cycle pulse on normal completion
prog_err  output  1  sticky error flag

Behaviour:
- Reset (sync, active-high): state IDLE; instruction=0, instr_valid=0, pc=0, busy=0, done=0, prog_err=0, gap counter=0. RAM contents are not reset.
- All outputs are registered. RAM has an asynchronous read and a synchronous write.
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE:
  - prog_we=1 writes prog_data to RAM[prog_addr] at the edge.
  - start=1 with 1<=prog_len<=DEPTH: latch len, pc<=0, prog_err<=0, go to RUN.
  - start=1 with prog_len==0 or prog_len>DEPTH: set prog_err, stay IDLE, no done.
- RUN, each edge:
  - stall=1: instruction<=0, instr_valid<=0, pc holds.
  - stall=0: instruction<=RAM[pc][23:0], instr_valid<=1, pc<=pc+1, gap counter<=RAM[pc] bubble field. Next state:
    - bubble field!=0: GAP.
    - pc+1==len and bubble field==0: DONE.
    - otherwise: stay RUN.
- GAP, each edge:
  - instruction<=0, instr_valid<=0; counter decrements regardless of stall.
  - When the counter reaches 0 on an edge: go to DONE if pc==len, else RUN.
  - A bubble of d gives exactly d zero cycles after the issued word.
- DONE: done=1 for exactly one cycle; instruction=0; then IDLE. pc is left at len (mod DEPTH) for observation.
- Issue latency: start at edge E0 means the first word is valid after E1 (assuming stall=0). Back-to-back words with no bubbles and no stall appear on consecutive cycles.
- While busy:
  - prog_we is ignored and sets prog_err.
  - start is ignored (no error).
- abort=1 in RUN/GAP/DONE: next edge forces IDLE, instruction=0, instr_valid=0, busy=0, no done pulse; pc holds. abort has priority over stall and start in the same cycle. abort in IDLE has no effect.
- Simultaneous start+prog_we in IDLE: the write is performed and the run starts. Word 0 is read after the write, so it reflects the new data if prog_addr==0.
- len==DEPTH: pc wraps to 0 after the last issue; completion is decided by the issued count, not by the pc value.
- busy = (state==RUN || state==GAP).

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined:
  - Adds input ports step_mode (1) and step (1).
  - When step_mode=1, RUN issues at most one word per rising pulse on step, sampled the same cycle; otherwise it behaves as stall=1.
  - GAP timing is unchanged.
- Undefined: the ports are absent and RUN issues whenever stall=0.

Test Plan:
1. Load entries 0..2 with words 0x860000, 0xC00001, 0x280002, bubbles 0; start with len=3 -> instr_valid high for 3 consecutive cycles starting one cycle after start, words in order; done pulses the cycle after the third word; busy then low.
2. Entry 0 word 0x8A0005 with bubble=3, entry 1 word 0x020007; len=2 -> word0, then three cycles of instruction=0/instr_valid=0, then word1, then done.
3. len=4, stall held high for 2 cycles after the second word -> two zero cycles, pc stays 2, then words 2 and 3 issue; total issued count is 4 and done pulses exactly once.
4. start with prog_len=0, then again with prog_len=DEPTH+1 -> prog_err=1, busy stays 0, no done; a valid start then clears prog_err.
5. Assert abort during the GAP of a 5-word program -> next cycle IDLE, busy=0, instruction=0, no done. prog_we during the run sets prog_err and the RAM entry is unchanged.
6. Assert rst mid-RUN -> all outputs 0 at the next edge. A restart reissues the previously loaded program unchanged, confirming RAM is not reset.
